// File: rtl/sp_sram_be_if.sv
// Bus bundle for the byte-enable single-port SRAM.
//   master : drives chip select, write strobe, address, byte enables,
//            write data and the clear request; receives read data,
//            read-valid strobe and busy flag.
//   slave  : the SRAM side of the same signals.
interface sp_sram_be_if #(
  parameter int ADDR_W     = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  iCsn;
  logic                  iWrn;
  logic [ADDR_W-1:0]     iAddr;
  logic [BE_W-1:0]       iBen;
  logic [DATA_WIDTH-1:0] iWrDt;
  logic                  iClr;
  logic [DATA_WIDTH-1:0] oRdDt;
  logic                  oRdVld;
  logic                  oBusy;

  modport master (
    output iCsn, iWrn, iAddr, iBen, iWrDt, iClr,
    input  oRdDt, oRdVld, oBusy
  );

  modport slave (
    input  iCsn, iWrn, iAddr, iBen, iWrDt, iClr,
    output oRdDt, oRdVld, oBusy
  );
endinterface

// File: rtl/sp_sram_be.sv
// Single-port SRAM model with byte-enable writes, 1- or 2-cycle read
// latency, optional write-through of the merged word and a clear
// sequencer that zeroes the array one word per cycle.
// Ports:
//   iClk  - rising-edge clock
//   iRsn  - asynchronous active-low reset (control and output regs only;
//           the array itself is never reset)
//   bus   - sp_sram_be_if.slave: iCsn/iWrn/iAddr/iBen/iWrDt/iClr in,
//           oRdDt/oRdVld/oBusy out
module sp_sram_be #(
  parameter int SRAM_DEPTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic        iClk,
  input  logic        iRsn,
  sp_sram_be_if.slave bus
);
  localparam int ADDR_W = (SRAM_DEPTH > 2) ? $clog2(SRAM_DEPTH) : 1;
  localparam int BE_W   = DATA_WIDTH / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SRAM_DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e                state_q;
  logic [ADDR_W-1:0]     cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [SRAM_DEPTH];

  logic                  idle;
  logic                  acc;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  rd_vld_p0;
  logic [DATA_WIDTH-1:0] rd_dt_p0;
  logic                  out_vld_in;
  logic [DATA_WIDTH-1:0] out_dt_in;
  logic                  rd_vld_d, rd_vld_q;
  logic [DATA_WIDTH-1:0] rd_dt_d, rd_dt_q;

  // Clear sequencer: one zero-write per cycle from address 0 up to the
  // last word, then back to IDLE with the counter parked at 0.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.iClr) state_q <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (cnt_q == LAST_ADDR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign idle     = (state_q == ST_IDLE);
  assign acc      = idle && !bus.iCsn;
  assign in_range = (32'(bus.iAddr) < 32'(SRAM_DEPTH));
  assign rd_word  = in_range ? mem_q[bus.iAddr] : '0;

  always_comb begin
    wr_merged = rd_word;
    for (int b = 0; b < BE_W; b++) begin
      if (bus.iBen[b]) wr_merged[8*b +: 8] = bus.iWrDt[8*b +: 8];
    end
  end

  // The clear sequencer owns the write port while busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.iAddr;
    mem_wdata = wr_merged;
    if (!idle) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (acc && !bus.iWrn && in_range) begin
      mem_we = 1'b1;
    end
  end

  // Array storage: no reset; writes are held off while reset is asserted
  // so words not yet re-cleared keep their contents.
  always_ff @(posedge iClk) begin
    if (iRsn && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // ---- stage p0: request decode, read word or merged write word ----
  assign rd_vld_p0 = acc && (bus.iWrn || (RDW_MODE != 0));
  assign rd_dt_p0  = in_range ? (bus.iWrn ? rd_word : wr_merged) : '0;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  rd_vld_p1_q;
      logic [DATA_WIDTH-1:0] rd_dt_p1_q;

      // ---- stage p1: extra output register, drains regardless of busy ----
      always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) rd_vld_p1_q <= 1'b0;
        else       rd_vld_p1_q <= rd_vld_p0;
      end

      always_ff @(posedge iClk) begin
        if (rd_vld_p0) rd_dt_p1_q <= rd_dt_p0;
      end

      assign out_vld_in = rd_vld_p1_q;
      assign out_dt_in  = rd_dt_p1_q;
    end else begin : g_lat1
      assign out_vld_in = rd_vld_p0;
      assign out_dt_in  = rd_dt_p0;
    end
  endgenerate

  // ---- output stage: data holds between strobes ----
  always_comb begin
    rd_vld_d = out_vld_in;
    rd_dt_d  = out_vld_in ? out_dt_in : rd_dt_q;
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      rd_vld_q <= 1'b0;
      rd_dt_q  <= '0;
    end else begin
      rd_vld_q <= rd_vld_d;
      rd_dt_q  <= rd_dt_d;
    end
  end

  assign bus.oRdDt  = rd_dt_q;
  assign bus.oRdVld = rd_vld_q;
  assign bus.oBusy  = !idle;
endmodule
